// File: rtl/vga_pkg.sv
// Shared VGA definitions: coordinate width, default 640x480@60 raster
// timing, sync window bounds, reset player positions and the position set
// type used by the timing generator and the paint blocks.
package vga_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Default horizontal timing in pixels.
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int H_TOTAL    = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;

  // Default vertical timing in lines.
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;
  localparam int V_TOTAL    = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  // Player start positions: P1 top-left, P2 near the bottom-right corner.
  localparam coord_t P1_X_RST = 10'd0;
  localparam coord_t P1_Y_RST = 10'd0;
  localparam coord_t P2_X_RST = 10'd608;
  localparam coord_t P2_Y_RST = 10'd448;

  typedef struct packed {
    coord_t p1_x;
    coord_t p1_y;
    coord_t p2_x;
    coord_t p2_y;
  } pos_set_t;

  localparam pos_set_t POS_RST = '{P1_X_RST, P1_Y_RST, P2_X_RST, P2_Y_RST};

  // Inclusive window test used for the sync pulse decodes.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_pos_shadow.sv
// Player position shadow registers. Game logic offers a new position set
// with pos_valid; it is captured into a staging set and acknowledged for one
// clk. The staged set is copied to the frame-stable outputs only on the
// commit strobe (start of vertical blank), so the paint blocks never see a
// position change inside the visible region.
module vga_pos_shadow
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               commit,
  input  logic               pos_valid,
  input  logic [COORD_W-1:0] p1_x_in,
  input  logic [COORD_W-1:0] p1_y_in,
  input  logic [COORD_W-1:0] p2_x_in,
  input  logic [COORD_W-1:0] p2_y_in,
  output logic               pos_ack,
  output logic [COORD_W-1:0] p1_x,
  output logic [COORD_W-1:0] p1_y,
  output logic [COORD_W-1:0] p2_x,
  output logic [COORD_W-1:0] p2_y
);

  pos_set_t stage;
  pos_set_t live;
  logic     pending;
  logic     capture;

  // A set is taken whenever one is offered and no ack is currently showing;
  // this yields one ack every second clk while pos_valid is held.
  assign capture = pos_valid && !pos_ack;

  // Capture the offered set into staging and raise the one-clk ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage   <= '0;
      pos_ack <= 1'b0;
    end else begin
      pos_ack <= capture;
      if (capture) begin
        stage <= '{p1_x_in, p1_y_in, p2_x_in, p2_y_in};
      end
    end
  end

  // Pending tracks an uncommitted staging set; a capture in the commit clk
  // keeps it set so the newer values go out at the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (capture) begin
      pending <= 1'b1;
    end else if (commit) begin
      pending <= 1'b0;
    end
  end

  // Commit the old staging set at the frame boundary; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= POS_RST;
    end else if (commit && pending) begin
      live <= stage;
    end
  end

  assign p1_x = live.p1_x;
  assign p1_y = live.p1_y;
  assign p2_x = live.p2_x;
  assign p2_y = live.p2_y;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A prescaler derives the pixel strobe from the
// system clock; horizontal and vertical counters walk the raster and the
// sync, video_on and frame_start decodes are registered from the counters'
// next values so they line up with hc/vc with no extra latency. Player
// positions are double-buffered in vga_pos_shadow and committed at the start
// of vertical blank.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] hc,
  output logic [COORD_W-1:0] vc,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               pix_en,
  output logic               frame_start,
  input  logic [COORD_W-1:0] p1_x_in,
  input  logic [COORD_W-1:0] p1_y_in,
  input  logic [COORD_W-1:0] p2_x_in,
  input  logic [COORD_W-1:0] p2_y_in,
  input  logic               pos_valid,
  output logic               pos_ack,
  output logic [COORD_W-1:0] p1_x,
  output logic [COORD_W-1:0] p1_y,
  output logic [COORD_W-1:0] p2_x,
  output logic [COORD_W-1:0] p2_y
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  localparam coord_t H_LAST   = COORD_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = COORD_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS_C  = COORD_W'(H_VIS);
  localparam coord_t V_VIS_C  = COORD_W'(V_VIS);
  localparam coord_t HS_FIRST = COORD_W'(H_VIS + H_FP);
  localparam coord_t HS_LAST  = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = COORD_W'(V_VIS + V_FP);
  localparam coord_t VS_LAST  = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_nxt;
  coord_t           hc_nxt;
  coord_t           vc_nxt;
  logic             fs_nxt;
  logic             commit;

  assign pre_nxt = (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);

  // Prescaler; pix_en is registered from the next count so it is high
  // exactly while the prescaler sits at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      pix_en <= 1'b0;
    end else begin
      pre    <= pre_nxt;
      pix_en <= (pre_nxt == PRE_LAST);
    end
  end

  // Next raster position: advance one pixel per strobe, wrap line and frame.
  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (pix_en) begin
      if (hc == H_LAST) begin
        hc_nxt = '0;
        vc_nxt = (vc == V_LAST) ? '0 : vc + COORD_W'(1);
      end else begin
        hc_nxt = hc + COORD_W'(1);
      end
    end
  end

  // frame_start covers the whole first pixel of vertical blank; the commit
  // strobe is only the clk in which it rises, so positions update once.
  assign fs_nxt = (hc_nxt == '0) && (vc_nxt == V_VIS_C);
  assign commit = fs_nxt && !frame_start;

  // Raster counters and decodes, all taken from the next position so they
  // change in the same clk as the counters they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hsync       <= !in_window(hc_nxt, HS_FIRST, HS_LAST);
      vsync       <= !in_window(vc_nxt, VS_FIRST, VS_LAST);
      video_on    <= (hc_nxt < H_VIS_C) && (vc_nxt < V_VIS_C);
      frame_start <= fs_nxt;
    end
  end

  vga_pos_shadow u_pos_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit    (commit),
    .pos_valid (pos_valid),
    .p1_x_in   (p1_x_in),
    .p1_y_in   (p1_y_in),
    .p2_x_in   (p2_x_in),
    .p2_y_in   (p2_y_in),
    .pos_ack   (pos_ack),
    .p1_x      (p1_x),
    .p1_y      (p1_y),
    .p2_x      (p2_x),
    .p2_y      (p2_y)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (32x20 pixels, 4 clks per
// pixel) so several whole frames fit in a short run. A reference model
// derives the raster state from the number of clks since reset and tracks
// the position handshake at transaction level; it is compared every clk.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CD = 4;
  localparam int HV = 16, HF = 4, HS = 8, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int FRAME_CLKS = FRAME * CD;
  localparam int BUDGET = 3 * FRAME_CLKS;
  localparam logic [39:0] POS_RESET = {10'd0, 10'd0, 10'd608, 10'd448};

  logic       clk;
  logic       rst_n;
  logic [9:0] hc, vc;
  logic       hsync, vsync, video_on, pix_en, frame_start;
  logic [9:0] p1_x_in, p1_y_in, p2_x_in, p2_y_in;
  logic       pos_valid, pos_ack;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int          n;
  logic        m_ack, m_pend;
  logic [39:0] m_stg, m_out;
  logic [39:0] prev_pos;
  logic        have_prev;

  typedef struct {
    int          line;
    logic [39:0] base;
    int          step;
    int          hold;
    int          exp_acks;
    logic [39:0] exp_before;
    logic [39:0] exp_after;
  } vec_t;

  vec_t vecs [3];

  vga_timing_gen #(
    .CLK_DIV (CD),
    .H_VIS   (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_VIS   (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hc          (hc),
    .vc          (vc),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pix_en      (pix_en),
    .frame_start (frame_start),
    .p1_x_in     (p1_x_in),
    .p1_y_in     (p1_y_in),
    .p2_x_in     (p2_x_in),
    .p2_y_in     (p2_y_in),
    .pos_valid   (pos_valid),
    .pos_ack     (pos_ack),
    .p1_x        (p1_x),
    .p1_y        (p1_y),
    .p2_x        (p2_x),
    .p2_y        (p2_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] pos_now();
    return {p1_x, p1_y, p2_x, p2_y};
  endfunction

  task automatic drive(input logic [39:0] v, input logic valid);
    {p1_x_in, p1_y_in, p2_x_in, p2_y_in} = v;
    pos_valid = valid;
  endtask

  task automatic model_reset();
    n      = 0;
    m_ack  = 1'b0;
    m_pend = 1'b0;
    m_stg  = '0;
    m_out  = POS_RESET;
  endtask

  // One system clk: the latest offered set waits for the next start of
  // vertical blank; an offer is taken only when no ack is showing.
  task automatic model_edge();
    int   nx;
    logic boundary;
    nx = n + 1;
    boundary = (nx % CD == 0) && ((nx / CD) % FRAME == VV * HT);
    if (boundary && m_pend) begin
      m_out  = m_stg;
      m_pend = 1'b0;
    end
    if (pos_valid && !m_ack) begin
      m_stg  = {p1_x_in, p1_y_in, p2_x_in, p2_y_in};
      m_pend = 1'b1;
      m_ack  = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
    n = nx;
  endtask

  task automatic check_model();
    int          pre, p, h, v;
    logic [24:0] e, a;
    pre = n % CD;
    p   = n / CD;
    h   = p % HT;
    v   = (p / HT) % VT;
    e = {10'(h), 10'(v),
         !(h >= HV + HF && h < HV + HF + HS),
         !(v >= VV + VF && v < VV + VF + VS),
         (h < HV && v < VV),
         (pre == CD - 1),
         (h == 0 && v == VV)};
    a = {hc, vc, hsync, vsync, video_on, pix_en, frame_start};
    check("raster", 64'(a), 64'(e));
    check("positions", 64'({pos_ack, pos_now()}), 64'({m_ack, m_out}));
    if (rst_n && have_prev && video_on)
      check("stable_while_visible", 64'(pos_now()), 64'(prev_pos));
    have_prev = rst_n;
    prev_pos  = pos_now();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    @(negedge clk);
    if (!rst_n) model_reset();
    check_model();
  endtask

  task automatic wait_line(input int line);
    int k;
    for (k = 0; k < BUDGET && !(vc == 10'(line) && hc == '0); k++) tick();
    check("wait_line_in_budget", 64'(k < BUDGET), 64'(1));
  endtask

  task automatic wait_pix(input int h, input int v);
    int k;
    for (k = 0; k < BUDGET && !(pix_en && hc == 10'(h) && vc == 10'(v)); k++) tick();
    check("wait_pixel_in_budget", 64'(k < BUDGET), 64'(1));
  endtask

  task automatic wait_fs_rise();
    int   k;
    logic prev;
    prev = frame_start;
    for (k = 0; k < BUDGET; k++) begin
      tick();
      if (frame_start && !prev) break;
      prev = frame_start;
    end
    check("frame_start_in_budget", 64'(k < BUDGET), 64'(1));
  endtask

  initial begin
    int          e, acks, clks, hl, vl, k;
    logic        prev;
    logic [9:0]  d;

    vecs[0] = '{5, {10'd100, 10'd20, 10'd300, 10'd40}, 0, 1, 1, POS_RESET,
                {10'd100, 10'd20, 10'd300, 10'd40}};
    vecs[1] = '{8, {10'd200, 10'd210, 10'd220, 10'd230}, 1, 10, 5,
                {10'd100, 10'd20, 10'd300, 10'd40},
                {10'd208, 10'd218, 10'd228, 10'd238}};
    vecs[2] = '{3, {10'd10, 10'd11, 10'd12, 10'd13}, 5, 3, 2,
                {10'd208, 10'd218, 10'd228, 10'd238},
                {10'd20, 10'd21, 10'd22, 10'd23}};

    rst_n = 1'b0;
    drive('0, 1'b0);
    model_reset();
    have_prev = 1'b0;
    prev_pos  = '0;

    // Reset values.
    repeat (3) tick();
    check("reset_raster", 64'({hc, vc, hsync, vsync, video_on, pix_en, frame_start}),
          64'({10'd0, 10'd0, 5'b11100}));
    check("reset_positions", 64'({pos_ack, pos_now()}), 64'({1'b0, POS_RESET}));

    // First pixel advance after release.
    rst_n = 1'b1;
    for (e = 0; e < BUDGET && hc == '0; e++) tick();
    check("first_pixel_edges", 64'(e), 64'(CD));

    // Table of position updates.
    for (int i = 0; i < 3; i++) begin
      wait_line(vecs[i].line);
      acks = 0;
      for (int j = 0; j < vecs[i].hold; j++) begin
        d = 10'(j * vecs[i].step);
        drive(vecs[i].base + {d, d, d, d}, 1'b1);
        tick();
        acks += int'(pos_ack);
      end
      drive('0, 1'b0);
      repeat (2) begin
        tick();
        acks += int'(pos_ack);
      end
      check("vec_ack_count", 64'(acks), 64'(vecs[i].exp_acks));
      check("vec_held_before_frame", 64'(pos_now()), 64'(vecs[i].exp_before));
      wait_fs_rise();
      check("vec_committed", 64'(pos_now()), 64'(vecs[i].exp_after));
    end

    // Visible edge and raster wrap.
    wait_pix(HV - 1, 1);
    check("video_on_last_visible", 64'(video_on), 64'(1));
    tick();
    check("video_off_at_hvis", 64'({hc, video_on}), 64'({10'(HV), 1'b0}));
    wait_pix(HT - 1, VT - 1);
    tick();
    check("raster_wrap", 64'({hc, vc}), 64'(0));

    // Two free-running frames: length and sync widths.
    wait_fs_rise();
    for (int f = 0; f < 2; f++) begin
      clks = 0; hl = 0; vl = 0;
      prev = frame_start;
      for (k = 0; k < BUDGET; k++) begin
        tick();
        clks++;
        if (!hsync) hl++;
        if (!vsync) vl++;
        if (frame_start && !prev) break;
        prev = frame_start;
      end
      check("frame_clks", 64'(clks), 64'(FRAME_CLKS));
      check("hsync_low_clks", 64'(hl), 64'(VT * HS * CD));
      check("vsync_low_clks", 64'(vl), 64'(VS * HT * CD));
    end

    // Capture in the same clk as the commit.
    wait_line(2);
    drive({10'd100, 10'd101, 10'd102, 10'd103}, 1'b1);
    tick();
    drive('0, 1'b0);
    check("early_ack", 64'(pos_ack), 64'(1));
    wait_pix(HT - 1, VV - 1);
    drive({10'd50, 10'd51, 10'd52, 10'd53}, 1'b1);
    tick();
    drive('0, 1'b0);
    check("coincident_commit", 64'({frame_start, pos_ack, pos_now()}),
          64'({1'b1, 1'b1, 10'd100, 10'd101, 10'd102, 10'd103}));
    wait_fs_rise();
    check("coincident_next_frame", 64'(pos_now()),
          64'({10'd50, 10'd51, 10'd52, 10'd53}));

    // Random offers against the model.
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      drive({10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom)},
            ($urandom_range(0, 7) == 0));
      tick();
    end
    drive('0, 1'b0);
    tick();

    // Mid-frame reset with an update pending.
    wait_line(2);
    drive({10'd77, 10'd78, 10'd79, 10'd80}, 1'b1);
    tick();
    drive('0, 1'b0);
    wait_line(VV / 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_raster", 64'({hc, vc, hsync, vsync, video_on, pix_en, frame_start}),
          64'({10'd0, 10'd0, 5'b11100}));
    check("async_reset_positions", 64'({pos_ack, pos_now()}), 64'({1'b0, POS_RESET}));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("restart_origin", 64'({hc, vc}), 64'(0));
    wait_fs_rise();
    check("no_stale_commit", 64'(pos_now()), 64'(POS_RESET));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz in, 25 MHz pixel rate).
REQ-002 Parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels, for a total of 800.
REQ-003 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines, for a total of 525.
REQ-004 Port clk, input, 1: single system clock; all state is on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port hc, output, 10: horizontal pixel counter, 0..799, visible region 0..639.
REQ-007 Port vc, output, 10: vertical line counter, 0..524, visible region 0..479.
REQ-008 Port hsync and vsync, output, 1 each: sync pulses, active-low.
REQ-009 Port video_on, output, 1: high when hc<640 and vc<480.
REQ-010 Port pix_en, output, 1: one-clk strobe per pixel period.
REQ-011 Port frame_start, output, 1: one-pixel-period pulse at the start of vertical blank.
REQ-012 Ports p1_x_in, p1_y_in, p2_x_in, p2_y_in, input, 10 each: new player positions from game logic.
REQ-013 Port pos_valid, input, 1: new position set offered.
REQ-014 Port pos_ack, output, 1: position set accepted.
REQ-015 Ports p1_x, p1_y, p2_x, p2_y, output, 10 each: frame-stable positions for the paint blocks.

Function
REQ-016 The pixel prescaler SHALL count 0..CLK_DIV-1; pix_en SHALL be high in the clk where the prescaler equals CLK_DIV-1.
REQ-017 hc SHALL advance only on pix_en; at 799 it SHALL wrap to 0, and vc SHALL increment in the same clk.
REQ-018 vc SHALL wrap from 524 to 0 when hc wraps.
REQ-019 hsync SHALL be 0 for hc in 656..751 and 1 otherwise.
REQ-020 vsync SHALL be 0 for vc in 490..491 and 1 otherwise.
REQ-021 hsync, vsync and video_on SHALL be registered and aligned with the hc/vc values they decode, with zero extra latency.
REQ-022 frame_start SHALL be high for exactly the pixel period where hc=0 and vc=480.
REQ-023 Position handshake: when pos_valid=1 and pos_ack=0, the four inputs SHALL be captured into a staging set, a pending flag SHALL be set, and pos_ack SHALL go high for exactly one clk on the next clk.
REQ-024 pos_valid held high SHALL produce one ack every second clk; the latest capture wins.
REQ-025 Commit: in the clk that frame_start rises, if pending=1, staging SHALL be copied to p1_x..p2_y and pending SHALL be cleared; otherwise the outputs SHALL hold.
REQ-026 Simultaneous capture and commit: the commit SHALL use the old staging, the new values SHALL go to staging, pending SHALL remain set, and the new values SHALL commit at the next frame.
REQ-027 p1_x..p2_y SHALL never change while video_on=1.

Reset
REQ-028 While rst_n=0: prescaler, hc, vc = 0; hsync=1, vsync=1; video_on=1; pix_en=0; frame_start=0; pos_ack=0; pending=0; staging=0.
REQ-029 While rst_n=0, p1_x=0, p1_y=0, p2_x=608, p2_y=448.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, and the pending update SHALL be discarded.
REQ-031 After rst_n deasserts, the first pix_en SHALL occur CLK_DIV clks later.

Structure
REQ-032 Timing constants (totals, sync start/end), the reset player positions and the 10-bit coordinate width SHALL live in the shared package vga_pkg, which the paint blocks reuse.
REQ-033 One sub-module, vga_pos_shadow, SHALL hold the staging/commit/handshake logic; counters and sync decode SHALL stay in the top module.

Verification
REQ-034 Free-run 2 frames after reset: exactly 800*525*4 clks per frame; hsync low for 384 clks per line; vsync low for 2 lines (6400 clks).
REQ-035 Check hc=639→640 transition: video_on falls in the same clk that hc becomes 640; at hc=799, vc=524 → next hc=0, vc=0.
REQ-036 pos_valid pulse with p1_x_in=100, mid-frame (vc=200): pos_ack one clk later; p1_x stays 0 until frame_start, then becomes 100.
REQ-037 Capture coincident with frame_start (p1_x_in=50 over prior staging 100): p1_x=100 this frame, p1_x=50 at the next frame_start.
REQ-038 pos_valid held high for 10 clks with an incrementing value: exactly 5 acks; the last acked value is committed.
REQ-039 rst_n pulsed low at vc=300: all outputs return to their reset values asynchronously; no commit of pending data; the counters restart from 0,0.
